// File: rtl/gpio_cfg_pkg.sv
// Shared definitions for the GPIO pad configuration sequencer.
//   - Configuration word width and field bit positions.
//   - Reset value of a configuration word.
//   - Sequencer state encoding.
//   - Default pad count (matches OPENFRAME_IO_PADS).
package gpio_cfg_pkg;

    localparam int unsigned CFG_W         = 11;
    localparam int unsigned ADDR_W        = 6;
    localparam int unsigned NPADS_DEFAULT = 44;

    // Field bit positions inside a configuration word.
    localparam int unsigned DM_LSB          = 0;
    localparam int unsigned DM_MSB          = 2;
    localparam int unsigned IB_MODE_SEL_BIT = 3;
    localparam int unsigned VTRIP_SEL_BIT   = 4;
    localparam int unsigned SLOW_SEL_BIT    = 5;
    localparam int unsigned INP_DIS_BIT     = 6;
    localparam int unsigned ANALOG_EN_BIT   = 7;
    localparam int unsigned ANALOG_SEL_BIT  = 8;
    localparam int unsigned ANALOG_POL_BIT  = 9;
    localparam int unsigned HOLDOVER_BIT    = 10;

    typedef logic [CFG_W-1:0] cfg_word_t;

    // dm=001, input enabled, no drive, all other fields clear.
    localparam cfg_word_t CFG_RESET = 11'h001;

    typedef enum logic [1:0] {
        StIdle,
        StCopy,
        StSettle,
        StDone
    } seq_state_e;

endpackage

// File: rtl/gpio_cfg_bank.sv
// Shadow storage of NPADS configuration words.
//   clk, reset : clock and synchronous active-high reset
//   wr_en      : qualified write strobe (caller has already range/busy checked)
//   wr_addr    : write index
//   wr_data    : word to store
//   rd_addr    : read index; out-of-range indices read as 0
//   rd_data    : registered read data (old value on same-cycle write)
//   tap_addr   : copy index used by the sequencer
//   tap_data   : combinational shadow word at tap_addr
module gpio_cfg_bank
    import gpio_cfg_pkg::*;
#(
    parameter int unsigned NPADS = NPADS_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  cfg_word_t         wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output cfg_word_t         rd_data,
    input  logic [ADDR_W-1:0] tap_addr,
    output cfg_word_t         tap_data
);

    localparam logic [ADDR_W:0] NPADS_W = (ADDR_W + 1)'(NPADS);

    cfg_word_t mem_q [NPADS];
    cfg_word_t mem_d [NPADS];
    cfg_word_t rd_data_q, rd_data_d;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Reads sample mem_q, so a same-cycle write is not visible yet.
    always_comb begin
        rd_data_d = '0;
        if ({1'b0, rd_addr} < NPADS_W) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q     <= '{default: CFG_RESET};
            rd_data_q <= '0;
        end else begin
            mem_q     <= mem_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign tap_data = mem_q[tap_addr];

endmodule

// File: rtl/gpio_pad_cfg_sequencer.sv
// Shadow bank of per-pad GPIO configuration words with a paced apply sequence.
// A request copies the shadow bank into the live pad registers one pad per
// cycle, waits SETTLE_CYCLES, then pulses apply_ack.
//   clk, reset           : clock, synchronous active-high reset
//   cfg_wr_en/addr/data  : shadow bank write port
//   cfg_wr_err           : one-cycle pulse when a write is dropped
//   cfg_rd_addr/data     : shadow bank read-back, 1-cycle latency
//   apply_req            : level request, re-armed only after it is seen low
//   apply_ack            : one-cycle pulse at the end of a sequence
//   busy                 : high while a sequence is in progress
//   gpio_*               : per-pad fields fanned out from the live registers
module gpio_pad_cfg_sequencer
    import gpio_cfg_pkg::*;
#(
    parameter int unsigned NPADS         = NPADS_DEFAULT,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_wr_en,
    input  logic [ADDR_W-1:0] cfg_wr_addr,
    input  logic [CFG_W-1:0]  cfg_wr_data,
    output logic              cfg_wr_err,
    input  logic [ADDR_W-1:0] cfg_rd_addr,
    output logic [CFG_W-1:0]  cfg_rd_data,
    input  logic              apply_req,
    output logic              apply_ack,
    output logic              busy,
    output logic [NPADS-1:0]  gpio_dm2,
    output logic [NPADS-1:0]  gpio_dm1,
    output logic [NPADS-1:0]  gpio_dm0,
    output logic [NPADS-1:0]  gpio_ib_mode_sel,
    output logic [NPADS-1:0]  gpio_vtrip_sel,
    output logic [NPADS-1:0]  gpio_slow_sel,
    output logic [NPADS-1:0]  gpio_inp_dis,
    output logic [NPADS-1:0]  gpio_analog_en,
    output logic [NPADS-1:0]  gpio_analog_sel,
    output logic [NPADS-1:0]  gpio_analog_pol,
    output logic [NPADS-1:0]  gpio_holdover
);

    localparam logic [ADDR_W:0]   NPADS_W     = (ADDR_W + 1)'(NPADS);
    localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(NPADS - 1);
    localparam logic [7:0]        SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              arm_q, arm_d;
    logic              busy_q, busy_d;
    logic              ack_q, ack_d;
    logic              wr_err_q, wr_err_d;
    cfg_word_t         live_q [NPADS];
    cfg_word_t         live_d [NPADS];

    logic      wr_ok;
    cfg_word_t tap_data;

    // Writes are accepted only in range and only while no sequence runs.
    assign wr_ok    = cfg_wr_en && !busy_q && ({1'b0, cfg_wr_addr} < NPADS_W);
    assign wr_err_d = cfg_wr_en && !wr_ok;

    gpio_cfg_bank #(
        .NPADS (NPADS)
    ) u_bank (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_ok),
        .wr_addr  (cfg_wr_addr),
        .wr_data  (cfg_wr_data),
        .rd_addr  (cfg_rd_addr),
        .rd_data  (cfg_rd_data),
        .tap_addr (idx_q),
        .tap_data (tap_data)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        arm_d   = arm_q;
        live_d  = live_q;

        // Re-arm whenever the request is seen low, so a held request fires once.
        if (!apply_req) begin
            arm_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                idx_d = '0;
                cnt_d = '0;
                if (apply_req && arm_q) begin
                    state_d = StCopy;
                    arm_d   = 1'b0;
                end
            end
            StCopy: begin
                live_d[idx_q] = tap_data;
                if (idx_q == LAST_IDX) begin
                    state_d = StSettle;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StSettle: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
        ack_d  = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            cnt_q    <= '0;
            arm_q    <= 1'b1;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
            wr_err_q <= 1'b0;
            live_q   <= '{default: CFG_RESET};
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            arm_q    <= arm_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
            wr_err_q <= wr_err_d;
            live_q   <= live_d;
        end
    end

    assign busy       = busy_q;
    assign apply_ack  = ack_q;
    assign cfg_wr_err = wr_err_q;

    for (genvar k = 0; k < NPADS; k++) begin : g_pad
        assign gpio_dm0[k]         = live_q[k][DM_LSB];
        assign gpio_dm1[k]         = live_q[k][DM_LSB + 1];
        assign gpio_dm2[k]         = live_q[k][DM_MSB];
        assign gpio_ib_mode_sel[k] = live_q[k][IB_MODE_SEL_BIT];
        assign gpio_vtrip_sel[k]   = live_q[k][VTRIP_SEL_BIT];
        assign gpio_slow_sel[k]    = live_q[k][SLOW_SEL_BIT];
        assign gpio_inp_dis[k]     = live_q[k][INP_DIS_BIT];
        assign gpio_analog_en[k]   = live_q[k][ANALOG_EN_BIT];
        assign gpio_analog_sel[k]  = live_q[k][ANALOG_SEL_BIT];
        assign gpio_analog_pol[k]  = live_q[k][ANALOG_POL_BIT];
        assign gpio_holdover[k]    = live_q[k][HOLDOVER_BIT];
    end

endmodule

// File: tb/tb_gpio_pad_cfg_sequencer.sv
// Scoreboard bench for gpio_pad_cfg_sequencer. Stimulus pushes expected
// observations (with the cycle they are due) into queues; a monitor on the
// falling edge pops and compares them against the DUT outputs.
module tb_gpio_pad_cfg_sequencer;

    localparam int NP = 44;
    localparam int ST = 4;
    localparam logic [10:0] RST_WORD = 11'h001;

    localparam int KPAD  = 0;
    localparam int KBUSY = 1;
    localparam int KRD   = 2;
    localparam int KACK  = 3;

    typedef struct {
        int          cyc;
        int          kind;
        int          idx;
        logic [10:0] val;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_wr_en;
    logic [5:0]    cfg_wr_addr;
    logic [10:0]   cfg_wr_data;
    logic          cfg_wr_err;
    logic [5:0]    cfg_rd_addr;
    logic [10:0]   cfg_rd_data;
    logic          apply_req;
    logic          apply_ack;
    logic          busy;
    logic [NP-1:0] gpio_dm2, gpio_dm1, gpio_dm0;
    logic [NP-1:0] gpio_ib_mode_sel, gpio_vtrip_sel, gpio_slow_sel, gpio_inp_dis;
    logic [NP-1:0] gpio_analog_en, gpio_analog_sel, gpio_analog_pol, gpio_holdover;

    gpio_pad_cfg_sequencer #(
        .NPADS         (NP),
        .SETTLE_CYCLES (ST)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .cfg_wr_en        (cfg_wr_en),
        .cfg_wr_addr      (cfg_wr_addr),
        .cfg_wr_data      (cfg_wr_data),
        .cfg_wr_err       (cfg_wr_err),
        .cfg_rd_addr      (cfg_rd_addr),
        .cfg_rd_data      (cfg_rd_data),
        .apply_req        (apply_req),
        .apply_ack        (apply_ack),
        .busy             (busy),
        .gpio_dm2         (gpio_dm2),
        .gpio_dm1         (gpio_dm1),
        .gpio_dm0         (gpio_dm0),
        .gpio_ib_mode_sel (gpio_ib_mode_sel),
        .gpio_vtrip_sel   (gpio_vtrip_sel),
        .gpio_slow_sel    (gpio_slow_sel),
        .gpio_inp_dis     (gpio_inp_dis),
        .gpio_analog_en   (gpio_analog_en),
        .gpio_analog_sel  (gpio_analog_sel),
        .gpio_analog_pol  (gpio_analog_pol),
        .gpio_holdover    (gpio_holdover)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t lvl_q[$];
    int   ack_exp[$];
    int   err_exp[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [10:0] pad_word(input int k);
        return {gpio_holdover[k], gpio_analog_pol[k], gpio_analog_sel[k], gpio_analog_en[k],
                gpio_inp_dis[k], gpio_slow_sel[k], gpio_vtrip_sel[k], gpio_ib_mode_sel[k],
                gpio_dm2[k], gpio_dm1[k], gpio_dm0[k]};
    endfunction

    function automatic logic [10:0] sample(input int kind, input int idx);
        case (kind)
            KPAD:    return pad_word(idx);
            KBUSY:   return {10'b0, busy};
            KRD:     return cfg_rd_data;
            default: return {10'b0, apply_ack};
        endcase
    endfunction

    function automatic string kind_name(input int kind);
        case (kind)
            KPAD:    return "pad";
            KBUSY:   return "busy";
            KRD:     return "rd_data";
            default: return "apply_ack";
        endcase
    endfunction

    // Cryptic but compact: v(k) gives 44 distinct words spread over all bits.
    function automatic logic [10:0] pat(input int k);
        return 11'((k * 45 + 'h2a5) % 2048);
    endfunction

    // Monitor: level checks due this cycle, plus pulse checks for ack and err.
    logic [10:0] mon_got;
    always @(negedge clk) begin
        for (int i = lvl_q.size() - 1; i >= 0; i--) begin
            if (lvl_q[i].cyc <= cyc) begin
                mon_got = sample(lvl_q[i].kind, lvl_q[i].idx);
                n_vec++;
                if (lvl_q[i].cyc < cyc || mon_got !== lvl_q[i].val) begin
                    n_bad++;
                    $display("FAIL %s[%0d] at cycle %0d: got %h, expected %h",
                             kind_name(lvl_q[i].kind), lvl_q[i].idx, cyc, mon_got,
                             lvl_q[i].val);
                end
                lvl_q.delete(i);
            end
        end
        if (ack_exp.size() > 0 && ack_exp[0] < cyc) begin
            n_vec++;
            n_bad++;
            $display("FAIL apply_ack missing: expected at cycle %0d, got none", ack_exp[0]);
            void'(ack_exp.pop_front());
        end
        if (apply_ack) begin
            n_vec++;
            if (ack_exp.size() > 0 && ack_exp[0] == cyc) begin
                void'(ack_exp.pop_front());
            end else begin
                n_bad++;
                $display("FAIL apply_ack unexpected at cycle %0d: got 1, expected 0", cyc);
            end
        end
        if (err_exp.size() > 0 && err_exp[0] < cyc) begin
            n_vec++;
            n_bad++;
            $display("FAIL cfg_wr_err missing: expected at cycle %0d, got none", err_exp[0]);
            void'(err_exp.pop_front());
        end
        if (cfg_wr_err) begin
            n_vec++;
            if (err_exp.size() > 0 && err_exp[0] == cyc) begin
                void'(err_exp.pop_front());
            end else begin
                n_bad++;
                $display("FAIL cfg_wr_err unexpected at cycle %0d: got 1, expected 0", cyc);
            end
        end
    end

    task automatic expect_lvl(input int c, input int kind, input int idx, input logic [10:0] v);
        exp_t e;
        e.cyc  = c;
        e.kind = kind;
        e.idx  = idx;
        e.val  = v;
        lvl_q.push_back(e);
    endtask

    task automatic do_write(input int addr, input logic [10:0] data, input bit ok);
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = 6'(addr);
        cfg_wr_data = data;
        if (!ok) err_exp.push_back(cyc + 1);
        @(negedge clk);
        cfg_wr_en = 1'b0;
    endtask

    task automatic do_read(input int addr, input logic [10:0] exp_v);
        cfg_rd_addr = 6'(addr);
        expect_lvl(cyc + 1, KRD, addr, exp_v);
        @(negedge clk);
    endtask

    // Pulses apply_req; c0 is the cycle in which it was raised (E0 = edge c0+1).
    task automatic start_apply(input bit exp_done, output int c0);
        apply_req = 1'b1;
        c0 = cyc;
        expect_lvl(c0 + 1, KBUSY, 0, 11'h001);
        if (exp_done) begin
            ack_exp.push_back(c0 + 1 + NP + ST);
            expect_lvl(c0 + 1 + NP + ST, KBUSY, 0, 11'h001);
            expect_lvl(c0 + 2 + NP + ST, KBUSY, 0, 11'h000);
        end
        @(negedge clk);
        apply_req = 1'b0;
    endtask

    initial begin
        int c;
        reset       = 1'b1;
        cfg_wr_en   = 1'b0;
        cfg_wr_addr = '0;
        cfg_wr_data = '0;
        cfg_rd_addr = 6'd5;
        apply_req   = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        expect_lvl(cyc + 1, KRD, 5, 11'h000);
        expect_lvl(cyc + 1, KBUSY, 0, 11'h000);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < NP; k++) expect_lvl(cyc + 1, KPAD, k, RST_WORD);
        expect_lvl(cyc + 1, KBUSY, 0, 11'h000);
        do_read(5, RST_WORD);

        // Single pad write, same-cycle write/read, then apply.
        do_write(3, 11'h006, 1'b1);
        do_read(3, 11'h006);
        cfg_rd_addr = 6'd4;
        expect_lvl(cyc + 1, KRD, 4, RST_WORD);
        do_write(4, 11'h123, 1'b1);
        do_read(4, 11'h123);
        start_apply(1'b1, c);
        expect_lvl(c + 4, KPAD, 3, RST_WORD);
        expect_lvl(c + 5, KPAD, 3, 11'h006);
        expect_lvl(c + 5, KPAD, 4, RST_WORD);
        expect_lvl(c + 6, KPAD, 4, 11'h123);
        repeat (8) @(negedge clk);
        do_write(7, 11'h7ff, 1'b0);          // dropped: busy
        repeat (42) @(negedge clk);
        do_write(50, 11'h055, 1'b0);         // dropped: out of range
        do_read(7, RST_WORD);
        do_read(50, 11'h000);
        expect_lvl(cyc + 1, KPAD, 7, RST_WORD);

        // Full bank, distinct values, apply and compare every pad.
        for (int k = 0; k < NP; k++) do_write(k, pat(k), 1'b1);
        for (int k = 0; k < NP; k++) do_read(k, pat(k));
        start_apply(1'b1, c);
        for (int k = 0; k < NP; k++) expect_lvl(c + 1 + NP, KPAD, k, pat(k));
        repeat (NP + ST + 2) @(negedge clk);
        // Shadow changes between sequences leave the live pads alone.
        do_write(0, 11'h000, 1'b1);
        do_read(0, 11'h000);
        expect_lvl(cyc + 3, KPAD, 0, pat(0));
        repeat (4) @(negedge clk);

        // Held request fires once; release and re-raise fires again.
        apply_req = 1'b1;
        c = cyc;
        ack_exp.push_back(c + 1 + NP + ST);
        expect_lvl(c + 2, KPAD, 0, 11'h000);
        expect_lvl(c + 2 + NP + ST, KBUSY, 0, 11'h000);
        repeat (100) @(negedge clk);
        expect_lvl(cyc + 1, KBUSY, 0, 11'h000);
        apply_req = 1'b0;
        @(negedge clk);
        start_apply(1'b1, c);
        repeat (NP + ST + 3) @(negedge clk);

        // Reset at E20 aborts the sequence with no ack.
        start_apply(1'b0, c);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < NP; k++) expect_lvl(c + 21, KPAD, k, RST_WORD);
        expect_lvl(c + 21, KBUSY, 0, 11'h000);
        expect_lvl(c + 1 + NP + ST, KACK, 0, 11'h000);
        @(negedge clk);
        reset = 1'b0;
        do_read(0, RST_WORD);
        do_read(18, RST_WORD);
        do_read(43, RST_WORD);
        repeat (NP + ST) @(negedge clk);

        // Anything still queued was never observed.
        foreach (lvl_q[i]) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s[%0d] never checked: due cycle %0d, expected %h",
                     kind_name(lvl_q[i].kind), lvl_q[i].idx, lvl_q[i].cyc, lvl_q[i].val);
        end
        foreach (ack_exp[i]) begin
            n_vec++;
            n_bad++;
            $display("FAIL apply_ack never seen: due cycle %0d", ack_exp[i]);
        end
        foreach (err_exp[i]) begin
            n_vec++;
            n_bad++;
            $display("FAIL cfg_wr_err never seen: due cycle %0d", err_exp[i]);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
